// File: rtl/mem_responder.sv
// mem_responder: multi-cycle data-memory responder with a configurable access latency.
// Defining MEM_RESP_WBUF_EN adds a single-entry posted write buffer (DRAIN state).
module mem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        stall,
   output logic        valid
);

   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
`ifdef MEM_RESP_WBUF_EN
   localparam logic [3:0] LAT_FULL = 4'(LATENCY);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      RESP  = 2'd2
`ifdef MEM_RESP_WBUF_EN
      , DRAIN = 2'd3
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  wr_q;
   logic [15:0]           wdata_q;
   logic                  valid_q;
   logic                  accept;
   logic                  rd_fire;
   logic                  commit;
   logic [15:0]           mem [DEPTH];

   // Bit 0 and the bits above the word index are deliberately dropped (aliasing).
   logic unused_addr;
   assign unused_addr = ^addr;

   // With LATENCY=1 the array is read on the accepting edge, before the index is latched.
   assign rd_idx = (state_q == IDLE) ? addr[DEPTH_LOG2:1] : idx_q;

   always_comb begin
      // NOTE: every combinational output is defaulted first so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      valid   = valid_q;
      accept  = 1'b0;
      rd_fire = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               accept = 1'b1;
`ifdef MEM_RESP_WBUF_EN
               if (wr) begin
                  valid   = 1'b1;
                  state_d = DRAIN;
                  cnt_d   = LAT_FULL;
               end else
`endif
               begin
                  stall = 1'b1;
                  if (LATENCY == 1) begin
                     state_d = RESP;
                     rd_fire = !wr;
                  end else begin
                     state_d = WAIT;
                     cnt_d   = LAT_M1;
                  end
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               rd_fire = !wr_q;
            end
         end
         RESP: begin
            state_d = IDLE;
            commit  = wr_q;
         end
`ifdef MEM_RESP_WBUF_EN
         DRAIN: begin
            stall = enable;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               commit  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         valid_q  <= 1'b0;
         data_out <= 16'h0000;
         wr_q     <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= (state_d == RESP);
         if (accept) begin
            idx_q   <= addr[DEPTH_LOG2:1];
            wr_q    <= wr;
            wdata_q <= data_in;
         end
         if (rd_fire) data_out <= mem[rd_idx];
      end
   end

   // NOTE: the array is never reset; a reset only blocks a pending commit.
   always_ff @(posedge clk) begin
      if (commit && !rst) mem[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder at LATENCY=4 and LATENCY=1.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst, en, wr, sel;
   logic [15:0] addr, din;
   logic        en4, en1;
   logic [15:0] dout4, dout1;
   logic        stall4, stall1, valid4, valid1;
   logic [15:0] cur_dout;
   logic        cur_stall, cur_valid;

   always #5 clk = ~clk;

   assign en4       = en & ~sel;
   assign en1       = en & sel;
   assign cur_dout  = sel ? dout1 : dout4;
   assign cur_stall = sel ? stall1 : stall4;
   assign cur_valid = sel ? valid1 : valid4;

   mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u4 (
      .clk(clk), .rst(rst), .enable(en4), .wr(wr), .addr(addr), .data_in(din),
      .data_out(dout4), .stall(stall4), .valid(valid4)
   );

   mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .enable(en1), .wr(wr), .addr(addr), .data_in(din),
      .data_out(dout1), .stall(stall1), .valid(valid1)
   );

   typedef struct {
      logic        sel;   // 0: LATENCY=4 instance, 1: LATENCY=1 instance
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;  // write data, or expected read data
   } vec_t;

   vec_t        vecs[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] last_rd [2];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic access(input vec_t v);
      int lat;
      lat = v.sel ? 1 : 4;
      @(posedge clk); #1;
      sel  = v.sel;
      en   = 1'b1;
      wr   = v.wr;
      addr = v.addr;
      din  = v.wr ? v.data : 16'h0000;
      @(negedge clk);
`ifdef MEM_RESP_WBUF_EN
      if (v.wr) begin
         check("posted_stall", cur_stall, 1'b0);
         check("posted_valid", cur_valid, 1'b1);
         for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 1) en = 1'b0;
            @(negedge clk);
            check("drain_valid", cur_valid, 1'b0);
         end
         return;
      end
`endif
      check("accept_stall", cur_stall, 1'b1);
      check("accept_valid", cur_valid, 1'b0);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            // Scramble the bus: only the latched copy may matter now.
            en   = 1'b0;
            addr = ~addr;
            din  = ~din;
            wr   = ~wr;
         end
         @(negedge clk);
         if (k < lat) begin
            check("wait_stall", cur_stall, 1'b1);
            check("wait_valid", cur_valid, 1'b0);
         end else begin
            check("resp_stall", cur_stall, 1'b0);
            check("resp_valid", cur_valid, 1'b1);
            if (v.wr) begin
               check("wr_hold_dout", cur_dout, last_rd[v.sel]);
            end else begin
               check("rd_data", cur_dout, v.data);
               last_rd[v.sel] = v.data;
            end
         end
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; wr = 1'b0; sel = 1'b0; addr = 16'h0; din = 16'h0;
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;

      // {sel, wr, addr, data/expected}
      vecs.push_back('{1'b0, 1'b1, 16'h0010, 16'hBEEF});
      vecs.push_back('{1'b0, 1'b0, 16'h0010, 16'hBEEF});
      vecs.push_back('{1'b0, 1'b1, 16'h0800, 16'h1234});
      vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h1234});
      vecs.push_back('{1'b0, 1'b1, 16'h07FE, 16'hA5C3});
      vecs.push_back('{1'b0, 1'b0, 16'hFFFE, 16'hA5C3});
      vecs.push_back('{1'b0, 1'b1, 16'h0021, 16'h5A5A});
      vecs.push_back('{1'b0, 1'b0, 16'h0020, 16'h5A5A});
      vecs.push_back('{1'b0, 1'b0, 16'h0010, 16'hBEEF});
      vecs.push_back('{1'b0, 1'b1, 16'h0010, 16'h0F0F});
      vecs.push_back('{1'b0, 1'b0, 16'h0011, 16'h0F0F});
      vecs.push_back('{1'b1, 1'b1, 16'h0040, 16'h1111});
      vecs.push_back('{1'b1, 1'b0, 16'h0040, 16'h1111});
      vecs.push_back('{1'b1, 1'b1, 16'h0003, 16'hC0DE});
      vecs.push_back('{1'b1, 1'b0, 16'h0002, 16'hC0DE});
      vecs.push_back('{1'b1, 1'b0, 16'h0840, 16'h1111});

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_stall4", stall4, 1'b0);
         check("idle_valid4", valid4, 1'b0);
         check("idle_dout4", dout4, 16'h0000);
         check("idle_stall1", stall1, 1'b0);
         check("idle_valid1", valid1, 1'b0);
         check("idle_dout1", dout1, 16'h0000);
      end

      foreach (vecs[i]) access(vecs[i]);

      // Reset in the middle of a read: outputs clear, no response.
      @(posedge clk); #1;
      sel = 1'b0; en = 1'b1; wr = 1'b0; addr = 16'h0020;
      @(negedge clk);
      check("rst_rd_accept_stall", stall4, 1'b1);
      @(posedge clk); #1 en = 1'b0;
      @(negedge clk);
      check("rst_rd_wait_stall", stall4, 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_rd_stall", stall4, 1'b0);
      check("rst_rd_valid", valid4, 1'b0);
      check("rst_rd_dout", dout4, 16'h0000);
      @(negedge clk);
      check("rst_rd_no_late_valid", valid4, 1'b0);
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;
      access('{1'b0, 1'b0, 16'h0020, 16'h5A5A});

      // Reset in the middle of a write: the write is discarded.
      @(posedge clk); #1;
      sel = 1'b0; en = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'hDEAD;
      @(posedge clk); #1 en = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_wr_stall", stall4, 1'b0);
      check("rst_wr_valid", valid4, 1'b0);
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;
      repeat (4) @(negedge clk);
      access('{1'b0, 1'b0, 16'h0020, 16'h5A5A});

`ifdef MEM_RESP_WBUF_EN
      // Posted write, then a read that must wait out the drain.
      @(posedge clk); #1;
      sel = 1'b0; en = 1'b1; wr = 1'b1; addr = 16'h0030; din = 16'h7777;
      @(negedge clk);
      check("wb_accept_stall", stall4, 1'b0);
      check("wb_accept_valid", valid4, 1'b1);
      @(posedge clk); #1;
      wr = 1'b0; din = 16'h0000;
      for (int t = 1; t <= 8; t++) begin
         @(negedge clk);
         check("wb_rd_stall", stall4, 1'b1);
         check("wb_rd_valid", valid4, 1'b0);
         @(posedge clk); #1;
         if (t == 5) en = 1'b0;
      end
      @(negedge clk);
      check("wb_rd_resp_valid", valid4, 1'b1);
      check("wb_rd_data", dout4, 16'h7777);
`endif

      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
